dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Pipeline-side initiator for the word-only data memory. Sits between the Memory stage and Dmem.
- Converts byte, halfword and word loads and stores into word accesses; read data is asynchronous and writes are synchronous.
- Sub-word stores use a two-cycle read-modify-write sequence and stall the pipeline for one cycle.
- Detects misaligned and out-of-range accesses, suppresses them, and flags them.

Parameters:
- ADDR_W, 32, address and data width.
- MEM_AW, 21, number of word-index bits implemented by the memory. Valid byte addresses are 0 to 2^(MEM_AW+2)-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; state is cleared on the rising clk edge when reset==0.
- MemReadM  in  1  load request in the M stage.
- MemWriteM  in  1  store request in the M stage.
- SizeM  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- SignedM  in  1  load result is sign-extended; when 0 it is zero-extended.
- AddrM  in  32  byte address (ALU result).
- WriteDataM  in  32  store data, right-justified.
- ReadDataM  out  32  extended load result.
- StallM  out  1  holds the F/D/E/M stages.
- FaultM  out  1  one-cycle pulse for an illegal access.
- DmemAddr  out  32  word-aligned address to memory (bits [1:0]=0).
- DmemWriteData  out  32  write word.
- DmemMemWrite  out  1  memory write enable.
- DmemReadData  in  32  asynchronous read word.

Behaviour:
- States: IDLE, RMW_WR. Registers: state, rmw_addr[31:0], rmw_data[31:0], FaultM.
- Reset values: state=IDLE, FaultM=0. StallM=0 and DmemMemWrite=0 while reset==0.
- Legal access: all of the following hold.
  - SizeM is not 11.
  - Alignment: half needs AddrM[0]=0; word needs AddrM[1:0]=0.
  - Range: AddrM[31:MEM_AW+2]==0.
- Illegal access: MemReadM or MemWriteM is set and the access is not legal.
  - No write occurs and ReadDataM=0.
  - FaultM=1 in the following cycle for exactly one cycle. FaultM is registered.
  - No stall.
- IDLE, load (MemReadM, legal):
  - DmemAddr={AddrM[31:2],2'b00}.
  - Lane select by AddrM[1:0] for byte, AddrM[1] for half. Lane 0 is bits [7:0] / [15:0] (little-endian).
  - Extend per SignedM. Result is combinational, zero latency, no stall.
- IDLE, word store (legal): DmemMemWrite=1 and DmemWriteData=WriteDataM in the same cycle; the write lands at that edge. No stall.
- IDLE, sub-word store (legal), two-cycle sequence:
  - IDLE cycle: StallM=1, DmemMemWrite=0, DmemAddr=word address.
  - At the edge, rmw_data takes DmemReadData with the addressed byte/half replaced by WriteDataM[7:0]/[15:0]. rmw_addr is captured. State goes to RMW_WR.
  - RMW_WR cycle: DmemAddr=rmw_addr, DmemWriteData=rmw_data, DmemMemWrite=1, StallM=0. Next state is IDLE.
  - Inputs are ignored in RMW_WR because the held store is still in M.
  - Total sub-word store latency is 2 cycles, with 1 stall cycle.
- MemReadM and MemWriteM both set: treated as illegal (fault, no access).
- Neither set: DmemMemWrite=0, DmemAddr=word address of AddrM, ReadDataM=0.
- Reset during RMW_WR: the write is suppressed that cycle, state=IDLE, and memory is unchanged.
- Back-to-back sub-word stores: each takes 2 cycles. The second read sees the first write because the write completes at the RMW_WR edge before the next IDLE read.
- Wrap-around: none. Addresses beyond range fault rather than alias.

Decomposition:
- Shared package mem_pkg holds:
  - enum access_size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD};
  - enum dmem_state_t {IDLE, RMW_WR};
  - function lane_merge(word, data, size, offset);
  - function lane_extract(word, size, offset, signed).
- One sub-module, dmem_lane_unit: combinational extract/extend and merge logic, used by the controller.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x100, load word 0x100 -> ReadDataM=0xDEADBEEF, StallM never 1.
- Byte RMW: memory[0x100]=0x11223344, store byte 0xAB at 0x102 -> StallM=1 for 1 cycle, DmemMemWrite only in the 2nd cycle, word becomes 0x11AB3344.
- Sign extension: memory[0x104]=0x0000F080, load half 0x104 with SignedM=1 -> 0xFFFFF080. Load byte 0x105 with SignedM=0 -> 0x000000F0.
- Faults: word load 0x102, half store 0x101, SizeM=11, AddrM=0x0080_0000 -> FaultM pulses next cycle, no DmemMemWrite, memory unchanged.
- Reset mid-RMW: sub-word store, reset=0 during RMW_WR -> no write, state IDLE, StallM=0 next cycle.
- Back-to-back byte stores 0x01 to 0x200 then 0x02 to 0x201 (word initially 0) -> final word 0x00000201.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the word-only data memory path.
//   access_size_t : load/store access size encoding (matches SizeM)
//   dmem_state_t  : controller sequencing states
//   lane_merge    : insert a byte/half/word into a memory word
//   lane_extract  : pull a byte/half/word out of a memory word and extend it
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned MEM_AW = 21;
  // Address bits at or above this index must be zero for an in-range access.
  localparam int unsigned RANGE_LSB = MEM_AW + 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } access_size_t;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } dmem_state_t;

  // Replace the addressed lane of word with the right-justified store data.
  function automatic logic [ADDR_W-1:0] lane_merge(
    input logic [ADDR_W-1:0] word,
    input logic [ADDR_W-1:0] data,
    input access_size_t      size,
    input logic [1:0]        offset
  );
    logic [ADDR_W-1:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{offset, 3'b000} +: 8] = data[7:0];
      SZ_HALF: begin
        if (offset[1]) r[31:16] = data[15:0];
        else           r[15:0]  = data[15:0];
      end
      SZ_WORD: r = data;
      default: r = word;
    endcase
    return r;
  endfunction

  // Select the addressed lane (little-endian) and sign- or zero-extend it.
  function automatic logic [ADDR_W-1:0] lane_extract(
    input logic [ADDR_W-1:0] word,
    input access_size_t      size,
    input logic [1:0]        offset,
    input logic              sgn
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [ADDR_W-1:0] r;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
      SZ_HALF: r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
      SZ_WORD: r = word;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane datapath for the data-memory controller.
//   rd_word      : word currently read from memory
//   wr_data      : right-justified store data
//   size         : access size
//   offset       : byte offset within the word (address bits [1:0])
//   sgn          : sign-extend load result when set
//   load_data_c  : extracted and extended load value
//   merge_data_c : rd_word with the addressed lane replaced by wr_data
module dmem_lane_unit
  import mem_pkg::*;
(
  input  logic [ADDR_W-1:0] rd_word,
  input  logic [ADDR_W-1:0] wr_data,
  input  access_size_t      size,
  input  logic [1:0]        offset,
  input  logic              sgn,
  output logic [ADDR_W-1:0] load_data_c,
  output logic [ADDR_W-1:0] merge_data_c
);

  always_comb begin
    load_data_c  = lane_extract(rd_word, size, offset, sgn);
    merge_data_c = lane_merge(rd_word, wr_data, size, offset);
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage initiator for the word-only data memory. Loads are served
// combinationally from the asynchronous read port; word stores write in the
// same cycle; byte/half stores run a read-modify-write over two cycles with a
// single stall cycle. Misaligned, out-of-range, reserved-size and conflicting
// requests are dropped and reported with a one-cycle FaultM pulse.
//   clk, reset      : clock, synchronous active-low reset
//   MemReadM/WriteM : load / store request
//   SizeM, SignedM  : access size and load extension mode
//   AddrM           : byte address
//   WriteDataM      : right-justified store data
//   ReadDataM       : extended load result (0 when no legal load)
//   StallM          : pipeline hold during the RMW read cycle
//   FaultM          : registered illegal-access pulse
//   Dmem*           : word-aligned memory interface
module dmem_access_ctrl
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [1:0]        SizeM,
  input  logic              SignedM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [ADDR_W-1:0] WriteDataM,
  output logic [ADDR_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              FaultM,
  output logic [ADDR_W-1:0] DmemAddr,
  output logic [ADDR_W-1:0] DmemWriteData,
  output logic              DmemMemWrite,
  input  logic [ADDR_W-1:0] DmemReadData
);

  dmem_state_t       state;
  dmem_state_t       state_nxt;
  logic [ADDR_W-1:0] rmw_addr;
  logic [ADDR_W-1:0] rmw_data;

  access_size_t      size;
  logic [ADDR_W-1:0] word_addr;
  logic              aligned;
  logic              in_range;
  logic              legal;
  logic              illegal;
  logic              rmw_start;
  logic [ADDR_W-1:0] load_data;
  logic [ADDR_W-1:0] merge_data;

  assign size      = access_size_t'(SizeM);
  assign word_addr = {AddrM[ADDR_W-1:2], 2'b00};

  // Legality of the request presented in M.
  always_comb begin
    case (size)
      SZ_HALF: aligned = ~AddrM[0];
      SZ_WORD: aligned = (AddrM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    in_range = (AddrM[ADDR_W-1:RANGE_LSB] == '0);
    legal    = (size != SZ_RSVD) && aligned && in_range;
    // A simultaneous read and write request is never serviced.
    illegal  = (MemReadM || MemWriteM) && (!legal || (MemReadM && MemWriteM));
  end

  dmem_lane_unit u_lane (
    .rd_word      (DmemReadData),
    .wr_data      (WriteDataM),
    .size         (size),
    .offset       (AddrM[1:0]),
    .sgn          (SignedM),
    .load_data_c  (load_data),
    .merge_data_c (merge_data)
  );

  // Next state and memory-side drive.
  always_comb begin
    state_nxt     = state;
    rmw_start     = 1'b0;
    DmemAddr      = word_addr;
    DmemWriteData = WriteDataM;
    DmemMemWrite  = 1'b0;
    StallM        = 1'b0;
    ReadDataM     = '0;
    case (state)
      IDLE: begin
        if (!illegal) begin
          if (MemReadM) begin
            ReadDataM = load_data;
          end else if (MemWriteM) begin
            if (size == SZ_WORD) begin
              DmemMemWrite = 1'b1;
            end else begin
              StallM    = 1'b1;
              rmw_start = 1'b1;
              state_nxt = RMW_WR;
            end
          end
        end
      end
      RMW_WR: begin
        // The stalled store is still presented in M; its inputs are ignored.
        DmemAddr      = rmw_addr;
        DmemWriteData = rmw_data;
        DmemMemWrite  = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset suppresses any stall or write, including a pending RMW write.
    if (!reset) begin
      DmemMemWrite = 1'b0;
      StallM       = 1'b0;
    end
  end

  // State, RMW holding registers and the fault pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      rmw_addr <= '0;
      rmw_data <= '0;
      FaultM   <= 1'b0;
    end else begin
      state  <= state_nxt;
      FaultM <= (state == IDLE) && illegal;
      if (rmw_start) begin
        rmw_addr <= word_addr;
        rmw_data <= merge_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural word memory and an
// expected-value queue checked against sampled DUT outputs.
module tb_dmem_access_ctrl;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [1:0]  SizeM;
  logic        SignedM;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        FaultM;
  logic [31:0] DmemAddr;
  logic [31:0] DmemWriteData;
  logic        DmemMemWrite;
  logic [31:0] DmemReadData;

  dmem_access_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .MemReadM      (MemReadM),
    .MemWriteM     (MemWriteM),
    .SizeM         (SizeM),
    .SignedM       (SignedM),
    .AddrM         (AddrM),
    .WriteDataM    (WriteDataM),
    .ReadDataM     (ReadDataM),
    .StallM        (StallM),
    .FaultM        (FaultM),
    .DmemAddr      (DmemAddr),
    .DmemWriteData (DmemWriteData),
    .DmemMemWrite  (DmemMemWrite),
    .DmemReadData  (DmemReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small word memory: async read, write at the rising edge. A bench-side
  // preload port shares the same process so the array has one writer.
  logic [31:0] mem [0:1023];
  logic        pl_we;
  logic [9:0]  pl_idx;
  logic [31:0] pl_data;

  assign DmemReadData = mem[DmemAddr[11:2]];

  always @(posedge clk) begin
    if (DmemMemWrite) mem[DmemAddr[11:2]] <= DmemWriteData;
    if (pl_we)        mem[pl_idx]         <= pl_data;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_obs(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic rd, input logic wr, input access_size_t sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd);
    MemReadM   = rd;
    MemWriteM  = wr;
    SizeM      = sz;
    SignedM    = sg;
    AddrM      = a;
    WriteDataM = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] d);
    pl_we   = 1'b1;
    pl_idx  = byte_addr[11:2];
    pl_data = d;
    tick();
    pl_we   = 1'b0;
  endtask

  // Check one legal load issued in an IDLE cycle.
  task automatic do_load(input string tag, input access_size_t sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] exp_data);
    tick();
    drive(1'b1, 1'b0, sz, sg, a, 32'h0);
    settle();
    expect_val({tag, "_data"}, exp_data);
    expect_val({tag, "_stall"}, 32'd0);
    check_obs(ReadDataM);
    check_obs({31'd0, StallM});
  endtask

  // Two-cycle sub-word store: stall on the read cycle, write on the next.
  task automatic do_sub_store(input string tag, input access_size_t sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_word);
    tick();
    drive(1'b0, 1'b1, sz, 1'b0, a, wd);
    settle();
    expect_val({tag, "_c1_stall"}, 32'd1);
    expect_val({tag, "_c1_we"}, 32'd0);
    expect_val({tag, "_c1_addr"}, {a[31:2], 2'b00});
    check_obs({31'd0, StallM});
    check_obs({31'd0, DmemMemWrite});
    check_obs(DmemAddr);
    tick();
    settle();
    expect_val({tag, "_c2_stall"}, 32'd0);
    expect_val({tag, "_c2_we"}, 32'd1);
    expect_val({tag, "_c2_wdata"}, exp_word);
    check_obs({31'd0, StallM});
    check_obs({31'd0, DmemMemWrite});
    check_obs(DmemWriteData);
    idle();
  endtask

  typedef struct {
    logic         rd;
    logic         wr;
    access_size_t sz;
    logic [31:0]  a;
  } fault_vec_t;

  fault_vec_t fvec [0:4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    pl_we       = 1'b0;
    pl_idx      = '0;
    pl_data     = '0;
    reset       = 1'b0;
    idle();

    // Reset: a sub-word store request must neither stall nor write.
    tick();
    drive(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h100, 32'hAB);
    settle();
    expect_val("rst_stall", 32'd0);
    expect_val("rst_we", 32'd0);
    check_obs({31'd0, StallM});
    check_obs({31'd0, DmemMemWrite});
    idle();
    preload(32'h200, 32'h0);
    settle();
    expect_val("rst_fault", 32'd0);
    check_obs({31'd0, FaultM});
    reset = 1'b1;

    // Word store then word load.
    tick();
    drive(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF);
    settle();
    expect_val("wst_stall", 32'd0);
    expect_val("wst_we", 32'd1);
    expect_val("wst_addr", 32'h100);
    check_obs({31'd0, StallM});
    check_obs({31'd0, DmemMemWrite});
    check_obs(DmemAddr);
    do_load("wld", SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF);

    // Byte read-modify-write into the upper-middle lane.
    idle();
    preload(32'h100, 32'h11223344);
    do_sub_store("brmw", SZ_BYTE, 32'h102, 32'hFFFF_FFAB, 32'h11AB3344);
    tick();
    expect_val("brmw_mem", 32'h11AB3344);
    check_obs(mem[32'h100 >> 2]);

    // Half store into the upper lane of a fresh word.
    idle();
    preload(32'h10C, 32'hAAAABBBB);
    do_sub_store("hrmw", SZ_HALF, 32'h10E, 32'h0000_5678, 32'h5678BBBB);

    // Extension and lane selection.
    idle();
    preload(32'h104, 32'h0000F080);
    do_load("ld_h_s",  SZ_HALF, 1'b1, 32'h104, 32'hFFFFF080);
    do_load("ld_b_u",  SZ_BYTE, 1'b0, 32'h105, 32'h000000F0);
    do_load("ld_b_s",  SZ_BYTE, 1'b1, 32'h105, 32'hFFFFFFF0);
    do_load("ld_h_hi", SZ_HALF, 1'b1, 32'h106, 32'h00000000);
    do_load("ld_b_0u", SZ_BYTE, 1'b0, 32'h104, 32'h00000080);

    // Illegal accesses: dropped, no stall, fault one cycle later only.
    fvec[0] = '{1'b1, 1'b0, SZ_WORD, 32'h0000_0102};
    fvec[1] = '{1'b0, 1'b1, SZ_HALF, 32'h0000_0101};
    fvec[2] = '{1'b1, 1'b0, SZ_RSVD, 32'h0000_0100};
    fvec[3] = '{1'b1, 1'b0, SZ_WORD, 32'h0080_0000};
    fvec[4] = '{1'b1, 1'b1, SZ_WORD, 32'h0000_0100};
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(fvec[i].rd, fvec[i].wr, fvec[i].sz, 1'b0, fvec[i].a, 32'hCAFE_F00D);
      settle();
      expect_val($sformatf("flt%0d_we", i), 32'd0);
      expect_val($sformatf("flt%0d_data", i), 32'd0);
      expect_val($sformatf("flt%0d_stall", i), 32'd0);
      expect_val($sformatf("flt%0d_early", i), 32'd0);
      check_obs({31'd0, DmemMemWrite});
      check_obs(ReadDataM);
      check_obs({31'd0, StallM});
      check_obs({31'd0, FaultM});
      tick();
      idle();
      settle();
      expect_val($sformatf("flt%0d_pulse", i), 32'd1);
      check_obs({31'd0, FaultM});
      tick();
      settle();
      expect_val($sformatf("flt%0d_clear", i), 32'd0);
      check_obs({31'd0, FaultM});
    end
    expect_val("flt_mem", 32'h11AB3344);
    check_obs(mem[32'h100 >> 2]);

    // Reset while the RMW write is pending.
    preload(32'h108, 32'h55667788);
    tick();
    drive(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h10A, 32'h1234);
    settle();
    expect_val("mrst_c1_stall", 32'd1);
    check_obs({31'd0, StallM});
    tick();
    reset = 1'b0;
    settle();
    expect_val("mrst_we", 32'd0);
    check_obs({31'd0, DmemMemWrite});
    tick();
    reset = 1'b1;
    idle();
    settle();
    expect_val("mrst_stall", 32'd0);
    expect_val("mrst_mem", 32'h55667788);
    check_obs({31'd0, StallM});
    check_obs(mem[32'h108 >> 2]);
    do_load("mrst_ld", SZ_WORD, 1'b0, 32'h108, 32'h55667788);

    // Back-to-back byte stores into one word.
    do_sub_store("bb1", SZ_BYTE, 32'h200, 32'h01, 32'h00000001);
    do_sub_store("bb2", SZ_BYTE, 32'h201, 32'h02, 32'h00000201);
    tick();
    expect_val("bb_mem", 32'h00000201);
    check_obs(mem[32'h200 >> 2]);
    do_load("bb_ld", SZ_HALF, 1'b0, 32'h200, 32'h00000201);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
